// File: rtl/mc_sequencer.sv
// mc_sequencer: multi-cycle instruction sequencer FSM.
//
// Walks each instruction through IF -> ID -> (EXE) -> (MEM) -> (WB) and back to IF.
// It issues memory requests in IF and MEM, and raises the IR/PC/register-file write
// enables. It counts retired instructions (cycles with PCWre=1). A request cycle that
// sees no mem_ack for TIMEOUT cycles sets a sticky error flag and parks the FSM in HALT.
//
// Ports:
//   clk_i, rst_ni           clock, asynchronous active-low reset
//   is_{jump,branch,load,store,halt}_i
//                           instruction class decoded from IR (only used in ID/EXE/MEM)
//   stall_i                 holds ID/EXE/WB and suppresses their write enables
//   mem_ack_i               completion of the current memory request
//   mem_req_o, mem_we_o     memory request and write qualifier
//   ir_wre_o, pc_wre_o, reg_wre_o
//                           IR / PC / register-file write enables
//   state_o                 current state (IF=000 ID=001 EXE=010 WB=011 MEM=100 HALT=111)
//   retired_o               retired-instruction count, wraps at 2^CNT_W
//   err_o                   sticky memory-timeout flag
module mc_sequencer #(
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             is_jump_i,
    input  logic             is_branch_i,
    input  logic             is_load_i,
    input  logic             is_store_i,
    input  logic             is_halt_i,
    input  logic             stall_i,
    input  logic             mem_ack_i,
    output logic             mem_req_o,
    output logic             mem_we_o,
    output logic             ir_wre_o,
    output logic             pc_wre_o,
    output logic             reg_wre_o,
    output logic [2:0]       state_o,
    output logic [CNT_W-1:0] retired_o,
    output logic             err_o
);

    typedef enum logic [2:0] {
        StIf   = 3'b000,
        StId   = 3'b001,
        StExe  = 3'b010,
        StWb   = 3'b011,
        StMem  = 3'b100,
        StHalt = 3'b111
    } state_e;

    // Wait count at which a still-unacknowledged request times out.
    localparam logic [7:0] WaitLast = 8'(TIMEOUT - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             err_q, err_d;
    logic [7:0]       wait_q, wait_d;
    logic             mem_store;
    logic             timeout;

    always_comb begin
        state_d   = state_q;
        err_d     = err_q;
        mem_req_o = 1'b0;
        mem_we_o  = 1'b0;
        ir_wre_o  = 1'b0;
        pc_wre_o  = 1'b0;
        reg_wre_o = 1'b0;
        timeout   = 1'b0;
        // A simultaneous load outranks a store, so MEM only writes for a pure store.
        mem_store = is_store_i & ~is_load_i;

        unique case (state_q)
            StIf: begin
                mem_req_o = 1'b1;
                if (mem_ack_i) begin
                    ir_wre_o = 1'b1;
                    state_d  = StId;
                end else if (wait_q == WaitLast) begin
                    timeout = 1'b1;
                end
            end
            StId: begin
                if (!stall_i) begin
                    if (is_halt_i) begin
                        state_d = StHalt;
                    end else if (is_jump_i) begin
                        pc_wre_o = 1'b1;
                        state_d  = StIf;
                    end else begin
                        state_d = StExe;
                    end
                end
            end
            StExe: begin
                if (!stall_i) begin
                    if (is_branch_i) begin
                        pc_wre_o = 1'b1;
                        state_d  = StIf;
                    end else if (is_load_i || is_store_i) begin
                        state_d = StMem;
                    end else begin
                        state_d = StWb;
                    end
                end
            end
            StMem: begin
                mem_req_o = 1'b1;
                mem_we_o  = mem_store;
                if (mem_ack_i) begin
                    if (mem_store) begin
                        pc_wre_o = 1'b1;
                        state_d  = StIf;
                    end else begin
                        state_d = StWb;
                    end
                end else if (wait_q == WaitLast) begin
                    timeout = 1'b1;
                end
            end
            StWb: begin
                if (!stall_i) begin
                    reg_wre_o = 1'b1;
                    pc_wre_o  = 1'b1;
                    state_d   = StIf;
                end
            end
            StHalt: begin
                state_d = StHalt;
            end
            default: begin
                state_d = StIf;
            end
        endcase

        if (timeout) begin
            state_d = StHalt;
            err_d   = 1'b1;
        end
    end

    // Any state change clears the wait count, so every entry to IF/MEM starts at 0;
    // staying in a request state implies no ack was seen that cycle.
    always_comb begin
        if (state_d != state_q) begin
            wait_d = '0;
        end else if (state_q == StIf || state_q == StMem) begin
            wait_d = wait_q + 8'd1;
        end else begin
            wait_d = wait_q;
        end
    end

    assign retired_d = retired_q + CNT_W'(pc_wre_o);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIf;
            retired_q <= '0;
            err_q     <= 1'b0;
            wait_q    <= '0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
            err_q     <= err_d;
            wait_q    <= wait_d;
        end
    end

    assign state_o   = state_q;
    assign retired_o = retired_q;
    assign err_o     = err_q;

endmodule

// File: tb/tb_mc_sequencer.sv
// Self-checking bench for mc_sequencer (CNT_W=4, TIMEOUT=4): a table of per-instruction
// state traces, hand-written multi-cycle corner sequences, then randomized stimulus
// compared against a behavioural model of the sequencing rules.
module tb_mc_sequencer;

    localparam int unsigned CW = 4;
    localparam int unsigned TO = 4;

    logic          clk, rst_n;
    logic          jmp, br, ld, st, hlt, stall, ack;
    logic          mem_req, mem_we, ir_wre, pc_wre, reg_wre;
    logic [2:0]    state;
    logic [CW-1:0] retired;
    logic          err;

    int n_vec = 0;
    int n_bad = 0;
    int exp_ret = 0;

    mc_sequencer #(.CNT_W(CW), .TIMEOUT(TO)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .is_jump_i   (jmp),
        .is_branch_i (br),
        .is_load_i   (ld),
        .is_store_i  (st),
        .is_halt_i   (hlt),
        .stall_i     (stall),
        .mem_ack_i   (ack),
        .mem_req_o   (mem_req),
        .mem_we_o    (mem_we),
        .ir_wre_o    (ir_wre),
        .pc_wre_o    (pc_wre),
        .reg_wre_o   (reg_wre),
        .state_o     (state),
        .retired_o   (retired),
        .err_o       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    // Per-instruction trace: state seen in each cycle from IF entry, as octal digits
    // (first cycle in the most significant digit), with ack=1 and no stall.
    typedef struct packed {
        logic            j, b, l, s, h;
        logic            we;
        logic [3:0]      len;
        logic [5:0][2:0] seq;
    } vec_t;
    vec_t tbl [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive inputs just after a falling edge and let them settle.
    task automatic drive(input logic j, b, l, s, h, stl, a);
        jmp = j; br = b; ld = l; st = s; hlt = h; stall = stl; ack = a;
        #1;
    endtask

    task automatic adv();
        @(negedge clk);
    endtask

    // Entered and left on a falling edge; after it the DUT sits in a fresh IF.
    task automatic do_reset();
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("reset state", 32'(state), 32'd0);
        chk("reset retired", 32'(retired), 32'd0);
        chk("reset err", 32'(err), 32'd0);
        adv();
        rst_n = 1'b1;
        exp_ret = 0;
    endtask

    task automatic run_vec(input int idx);
        vec_t v;
        logic [2:0] es;
        v = tbl[idx];
        for (int c = 0; c < int'(v.len); c++) begin
            es = v.seq[5-c];
            drive(v.j, v.b, v.l, v.s, v.h, 1'b0, 1'b1);
            chk($sformatf("tbl%0d state c%0d", idx, c), 32'(state), 32'(es));
            chk($sformatf("tbl%0d pcwre c%0d", idx, c), 32'(pc_wre), 32'(c == int'(v.len) - 1));
            chk($sformatf("tbl%0d regwre c%0d", idx, c), 32'(reg_wre), 32'(es == 3'd3));
            chk($sformatf("tbl%0d irwre c%0d", idx, c), 32'(ir_wre), 32'(c == 0));
            chk($sformatf("tbl%0d memwe c%0d", idx, c), 32'(mem_we),
                32'((es == 3'd4) ? v.we : 1'b0));
            adv();
        end
        exp_ret = (exp_ret + 1) % (1 << CW);
        #1;
        chk($sformatf("tbl%0d back in IF", idx), 32'(state), 32'd0);
        chk($sformatf("tbl%0d retired", idx), 32'(retired), 32'(exp_ret));
    endtask

    // Behavioural reference: what the sequencing rules demand for one cycle, given the
    // current state code, wait count and inputs.
    function automatic void model(input int cur, input int wt,
                                  input logic j, b, l, s, h, stl, a,
                                  output logic req, we, ir, pc, rg,
                                  output int nxt, output bit tmo);
        bit frozen;
        bit is_req;
        bit do_store;
        frozen   = stl && (cur == 1 || cur == 2 || cur == 3);
        is_req   = (cur == 0 || cur == 4);
        do_store = s && !l;
        req = is_req;
        we  = (cur == 4) && do_store;
        ir = 1'b0; pc = 1'b0; rg = 1'b0; nxt = cur; tmo = 1'b0;
        if (is_req && !a) begin
            if (wt == int'(TO) - 1) begin
                nxt = 7;
                tmo = 1'b1;
            end
        end else if (!frozen) begin
            case (cur)
                0: begin ir = 1'b1; nxt = 1; end
                1: if (h) nxt = 7; else if (j) begin pc = 1'b1; nxt = 0; end else nxt = 2;
                2: if (b) begin pc = 1'b1; nxt = 0; end else if (l || s) nxt = 4; else nxt = 3;
                3: begin pc = 1'b1; rg = 1'b1; nxt = 0; end
                4: if (do_store) begin pc = 1'b1; nxt = 0; end else nxt = 3;
                default: ;
            endcase
        end
    endfunction

    logic [2:0] lseq [9];
    logic       lack [9];

    initial begin
        int m_st, m_wait, m_ret, nxt, halted;
        bit m_err, tmo;
        logic e_req, e_we, e_ir, e_pc, e_rg;
        logic rj, rb, rl, rs, rh, rst_, ra;

        tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd4, 18'o012300}; // ALU
        tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2, 18'o010000}; // jump
        tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd3, 18'o012000}; // branch
        tbl[3] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd4, 18'o012400}; // store
        tbl[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd5, 18'o012430}; // load
        tbl[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd5, 18'o012430}; // load beats store
        tbl[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd2, 18'o010000}; // jump beats rest
        tbl[7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd3, 18'o012000}; // branch beats store

        lseq = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd4, 3'd4, 3'd4, 3'd3, 3'd0};
        lack = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        adv();
        do_reset();

        for (int i = 0; i < 8; i++) run_vec(i);

        // Halt: IF -> ID -> HALT, then nothing is enabled and nothing retires.
        drive(0, 0, 0, 0, 1, 0, 1); adv();
        drive(0, 0, 0, 0, 1, 0, 1); adv();
        for (int c = 0; c < 3; c++) begin
            drive(1, 1, 0, 0, 1, 0, 1);
            chk("halt state", 32'(state), 32'd7);
            chk("halt outputs", 32'({mem_req, mem_we, ir_wre, pc_wre, reg_wre}), 32'd0);
            adv();
        end
        chk("halt retired", 32'(retired), 32'(exp_ret));
        do_reset();

        // Load with ack 3 cycles late in MEM: MEM lasts 4 cycles with mem_we=0.
        for (int c = 0; c < 9; c++) begin
            drive(0, 0, 1, 0, 0, 0, lack[c]);
            chk($sformatf("late load state c%0d", c), 32'(state), 32'(lseq[c]));
            if (lseq[c] == 3'd4) begin
                chk("late load memwe", 32'({mem_req, mem_we}), 32'b10);
            end
            adv();
        end
        chk("late load retired", 32'(retired), 32'd1);
        do_reset();

        // Timeout in IF: four unacknowledged cycles then HALT with err, held for 100 cycles.
        for (int c = 0; c < 4; c++) begin
            drive(0, 0, 0, 0, 0, 0, 0);
            chk($sformatf("to IF c%0d", c), 32'({state, mem_req}), 32'b0001);
            adv();
        end
        for (int c = 0; c < 100; c++) begin
            drive(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                  1'($urandom), 1'($urandom));
            chk("timeout halt", 32'({state, err, mem_req, ir_wre, pc_wre, reg_wre}),
                32'b111_1_0000);
            adv();
        end
        do_reset();

        // Ack on the last permitted wait cycle wins over the timeout.
        for (int c = 0; c < 3; c++) begin
            drive(0, 0, 0, 0, 0, 0, 0); adv();
        end
        drive(0, 0, 0, 0, 0, 0, 1);
        chk("late ack irwre", 32'(ir_wre), 32'd1);
        adv();
        #1;
        chk("late ack state", 32'(state), 32'd1);
        chk("late ack err", 32'(err), 32'd0);
        do_reset();

        // 17 jumps wrap a 4-bit counter to 1.
        for (int k = 0; k < 17; k++) begin
            drive(1, 0, 0, 0, 0, 0, 1); adv();
            drive(1, 0, 0, 0, 0, 0, 1); adv();
        end
        #1;
        chk("jump wrap retired", 32'(retired), 32'd1);
        // ALU stalled in EXE for five cycles.
        drive(0, 0, 0, 0, 0, 0, 1); adv();
        drive(0, 0, 0, 0, 0, 0, 1); adv();
        for (int c = 0; c < 5; c++) begin
            drive(0, 1, 1, 0, 0, 1, 1);
            chk("stall exe", 32'({state, ir_wre, pc_wre, reg_wre}), 32'b010_000);
            adv();
        end
        drive(0, 0, 0, 0, 0, 0, 1); adv();
        drive(0, 0, 0, 0, 0, 0, 1);
        chk("post stall wb", 32'({state, pc_wre, reg_wre}), 32'b011_11);
        adv();
        #1;
        chk("post stall retired", 32'(retired), 32'd2);
        do_reset();

        // Reset in the middle of a MEM wait takes effect without a clock edge.
        drive(1, 0, 0, 0, 0, 0, 1); adv();
        drive(1, 0, 0, 0, 0, 0, 1); adv();
        drive(0, 0, 1, 0, 0, 0, 1); adv();
        drive(0, 0, 1, 0, 0, 0, 0); adv();
        drive(0, 0, 1, 0, 0, 0, 0); adv();
        drive(0, 0, 1, 0, 0, 0, 0);
        chk("mem wait state", 32'({state, retired}), 32'({3'd4, 4'd1}));
        adv();
        #2;
        rst_n = 1'b0;
        #1;
        chk("async reset", 32'({state, retired, err}), 32'd0);
        adv();
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 1);
        chk("refetch", 32'({mem_req, mem_we, ir_wre}), 32'b101);
        adv();
        #1;
        chk("refetch state", 32'(state), 32'd1);
        adv();
        do_reset();

        // Randomized run against the reference model.
        m_st = 0; m_wait = 0; m_ret = 0; m_err = 1'b0; halted = 0;
        for (int c = 0; c < 3000; c++) begin
            rj = ($urandom_range(0, 3) == 0);
            rb = ($urandom_range(0, 3) == 0);
            rl = ($urandom_range(0, 3) == 0);
            rs = ($urandom_range(0, 3) == 0);
            rh = ($urandom_range(0, 15) == 0);
            rst_ = ($urandom_range(0, 3) == 0);
            ra = ($urandom_range(0, 9) < 7);
            if ((m_st == 7 && $urandom_range(0, 3) == 0) || $urandom_range(0, 99) == 0) begin
                rst_n = 1'b0;
                m_st = 0; m_wait = 0; m_ret = 0; m_err = 1'b0;
                drive(rj, rb, rl, rs, rh, rst_, ra);
                model(m_st, m_wait, rj, rb, rl, rs, rh, rst_, ra,
                      e_req, e_we, e_ir, e_pc, e_rg, nxt, tmo);
                chk("rand reset", 32'({state, retired, err, mem_req, mem_we, ir_wre, pc_wre,
                    reg_wre}), 32'({3'(m_st), 4'(m_ret), m_err, e_req, e_we, e_ir, e_pc, e_rg}));
                adv();
                rst_n = 1'b1;
            end else begin
                drive(rj, rb, rl, rs, rh, rst_, ra);
                model(m_st, m_wait, rj, rb, rl, rs, rh, rst_, ra,
                      e_req, e_we, e_ir, e_pc, e_rg, nxt, tmo);
                chk("rand cycle", 32'({state, retired, err, mem_req, mem_we, ir_wre, pc_wre,
                    reg_wre}), 32'({3'(m_st), 4'(m_ret), m_err, e_req, e_we, e_ir, e_pc, e_rg}));
                m_ret = (m_ret + int'(e_pc)) % (1 << CW);
                if (tmo) m_err = 1'b1;
                if (nxt != m_st) m_wait = 0;
                else if (m_st == 0 || m_st == 4) m_wait = m_wait + 1;
                if (m_st == 7) halted++;
                m_st = nxt;
                adv();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/mc_sequencer.md
MC_SEQUENCER -- requirements
Module: mc_sequencer

Interface
REQ-001 The block SHALL have parameter CNT_W, default 16, giving the width of the retired-instruction counter.
REQ-002 The block SHALL have parameter TIMEOUT, default 16, giving the maximum number of cycles to wait for mem_ack (legal range 2..255).
REQ-003 CLK  in  1  single clock; all state changes on rising edge.
REQ-004 Reset  in  1  asynchronous, active-low reset.
REQ-005 is_jump, is_branch, is_load, is_store, is_halt  in  1 each  instruction class decoded from IR; sampled in ID/EXE/MEM only.
REQ-006 stall  in  1  freezes the FSM in ID, EXE and WB.
REQ-007 mem_ack  in  1  memory completion for the current request.
REQ-008 mem_req  out  1  memory request; mem_we  out  1  write qualifier.
REQ-009 IRWre, PCWre, RegWre  out  1 each  write enables for the IR, PC and register file.
REQ-010 state  out  3  current state; retired  out  CNT_W  retired-instruction count; err  out  1  memory timeout flag.

Function
REQ-011 The state encoding SHALL be IF=000, ID=001, EXE=010, WB=011, MEM=100, HALT=111; no other codes are reachable.
REQ-012 state, retired, err and the wait counter SHALL be registered; mem_req, mem_we, IRWre, PCWre and RegWre SHALL be combinational from state and inputs.
REQ-013 IF: mem_req=1 and mem_we=0; on mem_ack, IRWre=1 for that cycle and next state is ID; otherwise the FSM stays in IF.
REQ-014 ID: is_halt leads to HALT; else is_jump gives PCWre=1 and next state IF; else next state is EXE.
REQ-015 EXE: is_branch gives PCWre=1 and next state IF; else is_load or is_store leads to MEM; else WB.
REQ-016 MEM: mem_req=1 and mem_we=is_store; on mem_ack with a store, PCWre=1 and next state IF; on mem_ack with a load, next state WB.
REQ-017 WB: RegWre=1 and PCWre=1; next state is IF.
REQ-018 HALT: all enables and mem_req are 0; HALT is left only by Reset.
REQ-019 In ID, EXE and WB, stall=1 SHALL hold the state and force PCWre, RegWre and IRWre to 0; stall SHALL be ignored in IF, MEM and HALT.
REQ-020 Priority within a state SHALL be is_halt > is_jump > is_branch > is_load > is_store.
REQ-021 Latency with zero-wait memory (mem_ack in the first request cycle), IF entry to next IF entry, SHALL be: jump 2 cycles, branch 3, store 4, ALU 4, load 5.
REQ-022 The wait counter SHALL clear on every entry to IF or MEM and increment on each request cycle without mem_ack.
REQ-023 When the wait counter equals TIMEOUT-1 and mem_ack=0, err SHALL be set and the next state SHALL be HALT.
REQ-024 If mem_ack arrives in the timeout cycle, mem_ack SHALL win and err SHALL stay 0.
REQ-025 retired SHALL increment by 1 in every cycle where PCWre=1, wrapping from 2^CNT_W-1 to 0; HALT entry does not count.
REQ-026 err SHALL be sticky until Reset.

Reset
REQ-027 While Reset=0, state SHALL be IF, retired=0, err=0 and the wait counter=0, asynchronously and regardless of CLK.
REQ-028 Reset asserted mid-handshake SHALL abort the request; after release, the FSM SHALL restart a fresh fetch in IF.

Verification
REQ-029 ALU instruction with mem_ack tied to 1 -> state sequence 000,001,010,011,000; PCWre and RegWre high only in WB; retired=1.
REQ-030 Load with mem_ack delayed 3 cycles in MEM -> MEM lasts 4 cycles with mem_we=0, then WB; retired increments once.
REQ-031 TIMEOUT=4 and mem_ack never asserted in IF -> after 4 IF cycles, state=111 and err=1; HALT holds for 100 cycles.
REQ-032 mem_ack asserted exactly on wait count 3 with TIMEOUT=4 -> next state ID and err=0.
REQ-033 CNT_W=4, 17 jumps -> retired wraps to 1; stall=1 held in EXE for 5 cycles -> no enables and state stays 010.
REQ-034 Reset pulsed low during a MEM wait -> state 000, retired 0 and err 0 immediately; normal fetch resumes after release.
